// File: rtl/seq_control_if.sv
// Sequencer bus: program ROM fetch port, datapath control codes, start/done handshake.
// Latency: none, wires only.
// Backpressure: none; the sequencer paces itself and the environment follows state/busy/done.
//
// Signals:
//   start, step        environment -> sequencer  run request / single-step advance
//   instr_data[7:0]    ROM -> sequencer          opcode [7:4], operand [3:0], one cycle after instr_addr
//   acc_zero           datapath -> sequencer     accumulator == 0
//   instr_addr         sequencer -> ROM          program counter
//   tx, ty, tz, tula   sequencer -> datapath     register / ULA control codes
//   current_state      sequencer -> observer     encoded FSM state
//   busy, done         sequencer -> environment  executing / halted
// Modports: master = sequencer side, slave = environment (ROM, datapath, stimulus).
interface seq_control_if #(
   parameter int PC_W   = 4,
   parameter int CTRL_W = 4
);
   logic              start;
   logic              step;
   logic [7:0]        instr_data;
   logic              acc_zero;
   logic [PC_W-1:0]   instr_addr;
   logic [CTRL_W-1:0] tx;
   logic [CTRL_W-1:0] ty;
   logic [CTRL_W-1:0] tz;
   logic [CTRL_W-1:0] tula;
   logic [3:0]        current_state;
   logic              busy;
   logic              done;

   modport master (
      input  start, step, instr_data, acc_zero,
      output instr_addr, tx, ty, tz, tula, current_state, busy, done
   );

   modport slave (
      output start, step, instr_data, acc_zero,
      input  instr_addr, tx, ty, tz, tula, current_state, busy, done
   );
endinterface

// File: rtl/seq_control.sv
// Program sequencer: fetches 8-bit instructions from a synchronous ROM and sequences regs X/Y/Z and the ULA.
// Latency: 4 clocks per instruction (FETCH, DECODE, EXEC, WB); first FETCH the cycle after start is sampled.
// Backpressure: start ignored while busy; with SEQ_CONTROL_STEP_MODE_EN each instruction waits in PAUSE for step.
//
// Ports:
//   clock    rising-edge clock for all state
//   reset_n  synchronous active-low reset
//   bus      seq_control_if.master: start/step/instr_data/acc_zero in,
//            instr_addr/tx/ty/tz/tula/current_state/busy/done out
// Optional build macro: SEQ_CONTROL_STEP_MODE_EN (WB -> PAUSE, advance on step).
module seq_control #(
   parameter int PC_W   = 4,
   parameter int CTRL_W = 4
) (
   input logic           clock,
   input logic           reset_n,
   seq_control_if.master bus
);

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_FETCH  = 4'd1,
      ST_DECODE = 4'd2,
      ST_EXEC   = 4'd3,
      ST_WB     = 4'd4,
      ST_HALT   = 4'd5,
      ST_PAUSE  = 4'd6
   } state_t;

   localparam logic [3:0] OP_LDX  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_STZ  = 4'h6;
   localparam logic [3:0] OP_CLR  = 4'h7;
   localparam logic [3:0] OP_JMP  = 4'h8;
   localparam logic [3:0] OP_JZ   = 4'h9;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [CTRL_W-1:0] CODE_LOAD  = CTRL_W'(1);
   localparam logic [CTRL_W-1:0] CODE_CLEAR = CTRL_W'(2);
   localparam logic [CTRL_W-1:0] ULA_ADD    = CTRL_W'(0);
   localparam logic [CTRL_W-1:0] ULA_SUB    = CTRL_W'(1);
   localparam logic [CTRL_W-1:0] ULA_AND    = CTRL_W'(2);
   localparam logic [CTRL_W-1:0] ULA_OR     = CTRL_W'(3);

`ifdef SEQ_CONTROL_STEP_MODE_EN
   localparam state_t WB_NEXT = ST_PAUSE;
`else
   localparam state_t WB_NEXT = ST_FETCH;
   logic unused_step;
   assign unused_step = bus.step;
`endif

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [7:0]        ir_q, ir_d;
   logic              zero_q, zero_d;
   logic [CTRL_W-1:0] tx_q, tx_d;
   logic [CTRL_W-1:0] ty_q, ty_d;
   logic [CTRL_W-1:0] tz_q, tz_d;
   logic [CTRL_W-1:0] tula_q, tula_d;

   logic [PC_W-1:0]   pc_inc;
   logic [PC_W-1:0]   operand;

   assign pc_inc  = pc_q + PC_W'(1);
   assign operand = PC_W'(ir_q[3:0]);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         zero_q  <= 1'b0;
         tx_q    <= '0;
         ty_q    <= '0;
         tz_q    <= '0;
         tula_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         zero_q  <= zero_d;
         tx_q    <= tx_d;
         ty_q    <= ty_d;
         tz_q    <= tz_d;
         tula_q  <= tula_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      zero_d  = zero_q;
      // Codes default to 0 every cycle, so they are nonzero only in the
      // cycle following DECODE, i.e. exactly the EXEC cycle.
      tx_d    = '0;
      ty_d    = '0;
      tz_d    = '0;
      tula_d  = '0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_FETCH;
               pc_d    = '0;
            end
         end

         ST_FETCH: state_d = ST_DECODE;

         ST_DECODE: begin
            // ROM data for the FETCH address arrives now; decode it directly
            // so the codes register in time for EXEC.
            ir_d    = bus.instr_data;
            state_d = ST_EXEC;
            case (bus.instr_data[7:4])
               OP_LDX: tx_d = CODE_LOAD;
               OP_ADD: begin tula_d = ULA_ADD; ty_d = CODE_LOAD; end
               OP_SUB: begin tula_d = ULA_SUB; ty_d = CODE_LOAD; end
               OP_AND: begin tula_d = ULA_AND; ty_d = CODE_LOAD; end
               OP_OR:  begin tula_d = ULA_OR;  ty_d = CODE_LOAD; end
               OP_STZ: tz_d = CODE_LOAD;
               OP_CLR: begin tx_d = CODE_CLEAR; ty_d = CODE_CLEAR; end
               default: ;
            endcase
         end

         ST_EXEC: begin
            // Branch condition is the datapath flag as seen during EXEC.
            zero_d  = bus.acc_zero;
            state_d = ST_WB;
         end

         ST_WB: begin
            state_d = WB_NEXT;
            case (ir_q[7:4])
               OP_JMP:  pc_d = operand;
               OP_JZ:   pc_d = zero_q ? operand : pc_inc;
               OP_HALT: state_d = ST_HALT;
               default: pc_d = pc_inc;
            endcase
         end

         ST_HALT: begin
            if (bus.start) begin
               state_d = ST_FETCH;
               pc_d    = '0;
            end
         end

`ifdef SEQ_CONTROL_STEP_MODE_EN
         ST_PAUSE: begin
            if (bus.step) state_d = ST_FETCH;
         end
`endif

         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.instr_addr    = pc_q;
   assign bus.tx            = tx_q;
   assign bus.ty            = ty_q;
   assign bus.tz            = tz_q;
   assign bus.tula          = tula_q;
   assign bus.current_state = state_q;
   assign bus.busy          = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                              (state_q == ST_EXEC)  || (state_q == ST_WB) ||
                              (state_q == ST_PAUSE);
   assign bus.done          = (state_q == ST_HALT);

endmodule

// File: tb/tb_seq_control.sv
// Testbench for seq_control: program-level reference model against the sequencer.
// Latency: n/a.
// Backpressure: n/a.
module tb_seq_control;
   localparam int PC_W   = 4;
   localparam int CTRL_W = 4;

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   seq_control_if #(.PC_W(PC_W), .CTRL_W(CTRL_W)) bus ();

   seq_control #(.PC_W(PC_W), .CTRL_W(CTRL_W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Synchronous program ROM: data for an address is valid the next cycle.
   logic [7:0] rom [16];
   always @(posedge clock) bus.instr_data <= rom[bus.instr_addr];

   logic [15:0] codes_obs;
   assign codes_obs = {bus.tx, bus.ty, bus.tz, bus.tula};

   int errors = 0;
   int checks = 0;

   task automatic tick;
      @(negedge clock);
   endtask

   // Reference: {tx, ty, tz, tula} during EXEC for an opcode.
   function automatic logic [15:0] exp_ctrl(input logic [3:0] op);
      case (op)
         4'h1:    return 16'h1000;
         4'h2:    return 16'h0100;
         4'h3:    return 16'h0101;
         4'h4:    return 16'h0102;
         4'h5:    return 16'h0103;
         4'h6:    return 16'h0010;
         4'h7:    return 16'h2200;
         default: return 16'h0000;
      endcase
   endfunction

   // Reference: address of the next instruction (non-HALT opcodes).
   function automatic logic [3:0] next_pc(input logic [3:0] pc, input logic [7:0] ins, input bit az);
      if (ins[7:4] == 4'h8) return ins[3:0];
      if (ins[7:4] == 4'h9 && az) return ins[3:0];
      return 4'((int'(pc) + 1) % 16);
   endfunction

   task automatic clear_rom;
      foreach (rom[i]) rom[i] = 8'h00;
   endtask

   task automatic do_reset;
      reset_n  = 1'b0;
      bus.start = 1'b0;
      bus.step  = 1'b0;
      repeat (2) tick;
      reset_n = 1'b1;
   endtask

   // From FETCH, move to the next instruction's FETCH (non-HALT instruction).
   task automatic advance_instr;
      repeat (4) tick;
`ifdef SEQ_CONTROL_STEP_MODE_EN
      bus.step = 1'b1;
      tick;
      bus.step = 1'b0;
`endif
   endtask

   // Start from IDLE/HALT and execute up to max_instr instructions, checking
   // every phase against the program-level model.
   task automatic test_program_run(input string name, input int max_instr, input int az_mode);
      logic [3:0] mpc;
      logic [7:0] ins;
      bit         az;
      bit         halted;
      int         waits;
      halted = 1'b0;
      mpc    = 4'd0;
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      for (int k = 0; k < max_instr && !halted; k++) begin
         ins = rom[mpc];
         az  = (az_mode == 2) ? bit'($urandom_range(0, 1)) : bit'(az_mode);
         bus.acc_zero = az;
         checks++;
         if (bus.current_state !== 4'd1 || bus.instr_addr !== mpc || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_fetch k=%0d: state=%0d addr=%0d busy=%b, expected state=1 addr=%0d busy=1",
                     name, k, bus.current_state, bus.instr_addr, bus.busy, mpc);
         end
         bus.start = 1'($urandom_range(0, 1));
         tick;
         checks++;
         if (bus.current_state !== 4'd2 || codes_obs !== 16'h0000) begin
            errors++;
            $display("FAIL %s_decode k=%0d: state=%0d codes=%h, expected state=2 codes=0000",
                     name, k, bus.current_state, codes_obs);
         end
         tick;
         checks++;
         if (bus.current_state !== 4'd3 || codes_obs !== exp_ctrl(ins[7:4])) begin
            errors++;
            $display("FAIL %s_exec k=%0d op=%h: state=%0d codes=%h, expected state=3 codes=%h",
                     name, k, ins[7:4], bus.current_state, codes_obs, exp_ctrl(ins[7:4]));
         end
         bus.start = 1'b0;
         tick;
         checks++;
         if (bus.current_state !== 4'd4 || codes_obs !== 16'h0000 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL %s_wb k=%0d: state=%0d codes=%h done=%b, expected state=4 codes=0000 done=0",
                     name, k, bus.current_state, codes_obs, bus.done);
         end
         if (ins[7:4] == 4'hF) begin
            tick;
            checks++;
            if (bus.current_state !== 4'd5 || bus.done !== 1'b1 || bus.busy !== 1'b0 ||
                bus.instr_addr !== mpc) begin
               errors++;
               $display("FAIL %s_halt k=%0d: state=%0d done=%b busy=%b addr=%0d, expected state=5 done=1 busy=0 addr=%0d",
                        name, k, bus.current_state, bus.done, bus.busy, bus.instr_addr, mpc);
            end
            halted = 1'b1;
         end else begin
            mpc = next_pc(mpc, ins, az);
`ifdef SEQ_CONTROL_STEP_MODE_EN
            tick;
            checks++;
            if (bus.current_state !== 4'd6 || bus.busy !== 1'b1) begin
               errors++;
               $display("FAIL %s_pause k=%0d: state=%0d busy=%b, expected state=6 busy=1",
                        name, k, bus.current_state, bus.busy);
            end
            waits = $urandom_range(0, 2);
            for (int w = 0; w < waits; w++) begin
               tick;
               checks++;
               if (bus.current_state !== 4'd6) begin
                  errors++;
                  $display("FAIL %s_pause_wait k=%0d: state=%0d, expected 6", name, k, bus.current_state);
               end
            end
            bus.step = 1'b1;
            tick;
            bus.step = 1'b0;
`else
            waits = 0;
            bus.step = 1'($urandom_range(0, 1));
            tick;
`endif
         end
      end
      bus.step  = 1'b0;
      bus.start = 1'b0;
   endtask

   task automatic test_reset;
      checks++;
      if (bus.current_state !== 4'd0 || bus.instr_addr !== 4'd0 || codes_obs !== 16'h0000 ||
          bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL por_state: state=%0d addr=%0d codes=%h busy=%b done=%b, expected all 0",
                  bus.current_state, bus.instr_addr, codes_obs, bus.busy, bus.done);
      end
      clear_rom;
      rom[0] = 8'h11; rom[1] = 8'h20; rom[2] = 8'h60; rom[3] = 8'hF0;
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      advance_instr;
      repeat (2) tick;
      checks++;
      if (bus.current_state !== 4'd3 || codes_obs !== 16'h0100) begin
         errors++;
         $display("FAIL add_exec_before_reset: state=%0d codes=%h, expected state=3 codes=0100",
                  bus.current_state, codes_obs);
      end
      reset_n = 1'b0;
      repeat (3) tick;
      checks++;
      if (bus.current_state !== 4'd0 || bus.instr_addr !== 4'd0 || codes_obs !== 16'h0000 ||
          bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL mid_exec_reset: state=%0d addr=%0d codes=%h busy=%b done=%b, expected all 0",
                  bus.current_state, bus.instr_addr, codes_obs, bus.busy, bus.done);
      end
      reset_n = 1'b1;
      tick;
      checks++;
      if (bus.current_state !== 4'd0) begin
         errors++;
         $display("FAIL idle_hold: state=%0d, expected 0", bus.current_state);
      end
   endtask

   task automatic test_basic_program;
      clear_rom;
      rom[0] = 8'h11; rom[1] = 8'h20; rom[2] = 8'h60; rom[3] = 8'hF0;
      test_program_run("basic", 8, 0);
      for (int i = 0; i < 3; i++) begin
         tick;
         checks++;
         if (bus.done !== 1'b1 || bus.instr_addr !== 4'd3 || bus.current_state !== 4'd5 ||
             codes_obs !== 16'h0000) begin
            errors++;
            $display("FAIL halt_hold i=%0d: done=%b addr=%0d state=%0d codes=%h, expected done=1 addr=3 state=5 codes=0000",
                     i, bus.done, bus.instr_addr, bus.current_state, codes_obs);
         end
      end
   endtask

   task automatic test_jz;
      logic [3:0] want;
      for (int t = 0; t < 2; t++) begin
         clear_rom;
         rom[0] = 8'h95; rom[1] = 8'hF0; rom[5] = 8'hF0;
         do_reset;
         bus.acc_zero = (t == 0);
         want = (t == 0) ? 4'd5 : 4'd1;
         bus.start = 1'b1;
         tick;
         bus.start = 1'b0;
         advance_instr;
         checks++;
         if (bus.current_state !== 4'd1 || bus.instr_addr !== want) begin
            errors++;
            $display("FAIL jz_target az=%0d: state=%0d addr=%0d, expected state=1 addr=%0d",
                     (t == 0), bus.current_state, bus.instr_addr, want);
         end
      end
   endtask

   task automatic test_wrap;
      clear_rom;
      rom[0] = 8'h8F; rom[15] = 8'h00;
      do_reset;
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      advance_instr;
      checks++;
      if (bus.instr_addr !== 4'd15) begin
         errors++;
         $display("FAIL jmp_to_15: addr=%0d, expected 15", bus.instr_addr);
      end
      advance_instr;
      checks++;
      if (bus.current_state !== 4'd1 || bus.instr_addr !== 4'd0) begin
         errors++;
         $display("FAIL pc_wrap: state=%0d addr=%0d, expected state=1 addr=0",
                  bus.current_state, bus.instr_addr);
      end
   endtask

   task automatic test_restart;
      clear_rom;
      rom[0] = 8'h11; rom[1] = 8'hF0;
      do_reset;
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      advance_instr;
      repeat (4) tick;
      checks++;
      if (bus.current_state !== 4'd5 || bus.instr_addr !== 4'd1 || bus.done !== 1'b1) begin
         errors++;
         $display("FAIL halt_reached: state=%0d addr=%0d done=%b, expected state=5 addr=1 done=1",
                  bus.current_state, bus.instr_addr, bus.done);
      end
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      checks++;
      if (bus.current_state !== 4'd1 || bus.instr_addr !== 4'd0) begin
         errors++;
         $display("FAIL restart_fetch: state=%0d addr=%0d, expected state=1 addr=0",
                  bus.current_state, bus.instr_addr);
      end
      bus.start = 1'b1;
      repeat (3) tick;
      bus.start = 1'b0;
      checks++;
      if (bus.current_state !== 4'd4 || bus.instr_addr !== 4'd0) begin
         errors++;
         $display("FAIL busy_start_ignored: state=%0d addr=%0d, expected state=4 addr=0",
                  bus.current_state, bus.instr_addr);
      end
      tick;
`ifdef SEQ_CONTROL_STEP_MODE_EN
      bus.step = 1'b1;
      tick;
      bus.step = 1'b0;
`endif
      checks++;
      if (bus.current_state !== 4'd1 || bus.instr_addr !== 4'd1) begin
         errors++;
         $display("FAIL after_busy_start: state=%0d addr=%0d, expected state=1 addr=1",
                  bus.current_state, bus.instr_addr);
      end
      // start held high: HALT at address 0 restarts once per HALT entry.
      clear_rom;
      rom[0] = 8'hF0;
      do_reset;
      bus.start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick;
         checks++;
         if (bus.current_state !== 4'((i % 5) + 1) || bus.instr_addr !== 4'd0) begin
            errors++;
            $display("FAIL held_start i=%0d: state=%0d addr=%0d, expected state=%0d addr=0",
                     i, bus.current_state, bus.instr_addr, (i % 5) + 1);
         end
      end
      bus.start = 1'b0;
   endtask

   task automatic test_random_programs;
      for (int p = 0; p < 25; p++) begin
         foreach (rom[i]) rom[i] = 8'($urandom);
         do_reset;
         test_program_run("rand", 12, 2);
      end
   endtask

`ifdef SEQ_CONTROL_STEP_MODE_EN
   task automatic test_step_mode;
      clear_rom;
      rom[0] = 8'h11; rom[1] = 8'h20; rom[2] = 8'h20; rom[3] = 8'hF0;
      do_reset;
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      repeat (4) tick;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.current_state !== 4'd6 || bus.instr_addr !== 4'd1) begin
            errors++;
            $display("FAIL pause_hold i=%0d: state=%0d addr=%0d, expected state=6 addr=1",
                     i, bus.current_state, bus.instr_addr);
         end
         tick;
      end
      bus.step = 1'b1;
      tick;
      bus.step = 1'b0;
      checks++;
      if (bus.current_state !== 4'd1 || bus.instr_addr !== 4'd1) begin
         errors++;
         $display("FAIL step_fetch: state=%0d addr=%0d, expected state=1 addr=1",
                  bus.current_state, bus.instr_addr);
      end
      bus.step = 1'b1;
      repeat (5) tick;
      checks++;
      if (bus.current_state !== 4'd1 || bus.instr_addr !== 4'd2) begin
         errors++;
         $display("FAIL step_held_cadence: state=%0d addr=%0d, expected state=1 addr=2",
                  bus.current_state, bus.instr_addr);
      end
      bus.step = 1'b0;
      repeat (4) tick;
      reset_n = 1'b0;
      tick;
      reset_n = 1'b1;
      checks++;
      if (bus.current_state !== 4'd0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL pause_reset: state=%0d busy=%b, expected state=0 busy=0",
                  bus.current_state, bus.busy);
      end
   endtask
`endif

   initial begin
      clear_rom;
      reset_n      = 1'b0;
      bus.start    = 1'b0;
      bus.step     = 1'b0;
      bus.acc_zero = 1'b0;
      repeat (3) tick;
      reset_n = 1'b1;
      test_reset;
      test_basic_program;
      test_jz;
      test_wrap;
      test_restart;
      test_random_programs;
`ifdef SEQ_CONTROL_STEP_MODE_EN
      test_step_mode;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
